// File: rtl/ddr_maint_sched_if.sv
// Maintenance request/acknowledge handshake between the scheduler (master)
// and the DDR controller user maintenance port (slave).
interface ddr_maint_sched_if;
  logic app_ref_req;
  logic app_ref_ack;
  logic app_zq_req;
  logic app_zq_ack;
  logic app_sr_req;
  logic app_sr_active;

  modport master (
    output app_ref_req, app_zq_req, app_sr_req,
    input  app_ref_ack, app_zq_ack, app_sr_active
  );

  modport slave (
    input  app_ref_req, app_zq_req, app_sr_req,
    output app_ref_ack, app_zq_ack, app_sr_active
  );
endinterface

// File: rtl/ddr_maint_sched.sv
// DDR maintenance scheduler: periodic/software refresh, ZQ calibration and self-refresh sequencing.
// ZQ scheduling is compiled in only when DDR_MAINT_ZQ_EN is defined.
module ddr_maint_sched #(
  parameter int REFI_CYCLES  = 780,
  parameter int ZQI_CYCLES   = 128000,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int MAX_POSTPONE = 8
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_init_calib_done,
  input  logic              i_ena,
  input  logic              i_sw_ref_req,
  input  logic              i_sw_zq_req,
  input  logic              i_sr_enter,
  ddr_maint_sched_if.master app_if,
  output logic              o_sr_active,
  output logic [3:0]        o_ref_pending,
  output logic              o_busy,
  output logic              o_err,
  input  logic              i_err_clr
);

  localparam int         REFI_W   = $clog2(REFI_CYCLES + 1);
  localparam int         WD_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0] PEND_MAX = 5'(MAX_POSTPONE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_REF_WAIT,
`ifdef DDR_MAINT_ZQ_EN
    S_ZQ_WAIT,
`endif
    S_SR_ENTER,
    S_SR,
    S_SR_EXIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [REFI_W-1:0] r_refi;
  logic [WD_W-1:0]   r_wdog;
  logic [3:0]        r_pend;
  logic              r_ref_req;
  logic              r_sr_req;
  logic              r_sr_active;
  logic              r_err;

  logic              w_refi_tick;
  logic              w_ref_done;
  logic              w_ref_dec;
  logic              w_sr_entry;
  logic              w_in_wait;
  logic              w_timeout;
  logic              w_to_fire;
  logic              w_clear;
  logic              w_ovf;
  logic [4:0]        w_pend_sum;
  logic [3:0]        w_pend_nxt;

`ifdef DDR_MAINT_ZQ_EN
  localparam int ZQI_W = $clog2(ZQI_CYCLES + 1);

  logic [ZQI_W-1:0] r_zqi;
  logic             r_zq_pend;
  logic             r_zq_req;
  logic             w_zqi_tick;
  logic             w_zq_done;
`endif

  // Acks count only after the request pulse cycle and only in the matching wait state
  assign w_ref_done = (r_state == S_REF_WAIT) && !r_ref_req && app_if.app_ref_ack;
  assign w_ref_dec  = w_ref_done && (r_pend != 4'd0);

`ifdef DDR_MAINT_ZQ_EN
  assign w_zq_done  = (r_state == S_ZQ_WAIT) && !r_zq_req && app_if.app_zq_ack;
  assign w_in_wait  = (r_state == S_REF_WAIT) || (r_state == S_ZQ_WAIT) ||
                      (r_state == S_SR_ENTER) || (r_state == S_SR_EXIT);
`else
  assign w_in_wait  = (r_state == S_REF_WAIT) || (r_state == S_SR_ENTER) ||
                      (r_state == S_SR_EXIT);
`endif

  assign w_timeout   = w_in_wait && (r_wdog == WD_W'(ACK_TIMEOUT - 1));
  assign w_refi_tick = i_ena && (r_state != S_IDLE) && (r_state != S_SR) &&
                       (r_refi == REFI_W'(REFI_CYCLES - 1));
  assign w_clear     = (r_state == S_IDLE) || (w_next == S_IDLE);
  assign w_sr_entry  = (r_state == S_SR_ENTER) && (w_next == S_SR);

  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    if (!i_init_calib_done) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_READY;
        S_READY: begin
          if (i_sr_enter)            w_next = S_SR_ENTER;
          else if (r_pend != 4'd0)   w_next = S_REF_WAIT;
`ifdef DDR_MAINT_ZQ_EN
          else if (r_zq_pend)        w_next = S_ZQ_WAIT;
`endif
        end
        S_REF_WAIT: begin
          if (w_ref_done) w_next = S_READY;
          else if (w_timeout) begin
            w_next    = S_READY;
            w_to_fire = 1'b1;
          end
        end
`ifdef DDR_MAINT_ZQ_EN
        S_ZQ_WAIT: begin
          if (w_zq_done) w_next = S_READY;
          else if (w_timeout) begin
            w_next    = S_READY;
            w_to_fire = 1'b1;
          end
        end
`endif
        S_SR_ENTER: begin
          if (app_if.app_sr_active) w_next = S_SR;
          else if (w_timeout) begin
            w_next    = S_READY;
            w_to_fire = 1'b1;
          end
        end
        S_SR: if (!i_sr_enter) w_next = S_SR_EXIT;
        S_SR_EXIT: begin
          if (!app_if.app_sr_active) w_next = S_READY;
          else if (w_timeout) begin
            w_next    = S_READY;
            w_to_fire = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Pending refresh arithmetic: up to two increments and one decrement per cycle
  always_comb begin
    w_pend_sum = {1'b0, r_pend} + {4'b0, w_refi_tick} + {4'b0, i_sw_ref_req}
               - {4'b0, w_ref_dec};
    w_pend_nxt = w_pend_sum[3:0];
    w_ovf      = 1'b0;
    if (w_clear || w_sr_entry) begin
      w_pend_nxt = 4'd0;
    end else if (w_pend_sum > PEND_MAX) begin
      w_pend_nxt = PEND_MAX[3:0];
      w_ovf      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= S_IDLE;
      r_refi      <= '0;
      r_wdog      <= '0;
      r_pend      <= 4'd0;
      r_ref_req   <= 1'b0;
      r_sr_req    <= 1'b0;
      r_sr_active <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_nxt;

      // REFI restarts on self-refresh entry and holds at zero while in SR
      if (w_clear || w_sr_entry || w_refi_tick) r_refi <= '0;
      else if (i_ena && (r_state != S_SR))      r_refi <= r_refi + REFI_W'(1);

      if (!w_in_wait || (w_next != r_state)) r_wdog <= '0;
      else                                   r_wdog <= r_wdog + WD_W'(1);

      r_ref_req   <= (r_state == S_READY) && (w_next == S_REF_WAIT);
      r_sr_req    <= (w_next == S_SR_ENTER) || (w_next == S_SR);
      r_sr_active <= (w_next == S_SR);

      if (w_to_fire || w_ovf) r_err <= 1'b1;
      else if (i_err_clr)     r_err <= 1'b0;
    end
  end

`ifdef DDR_MAINT_ZQ_EN
  assign w_zqi_tick = i_ena && (r_state != S_IDLE) &&
                      (r_zqi == ZQI_W'(ZQI_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_zqi     <= '0;
      r_zq_pend <= 1'b0;
      r_zq_req  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_zqi     <= '0;
        r_zq_pend <= 1'b0;
      end else begin
        if (w_zqi_tick) r_zqi <= '0;
        else if (i_ena) r_zqi <= r_zqi + ZQI_W'(1);
        // A new request landing on the ack cycle keeps the bit set
        if (w_zqi_tick || i_sw_zq_req) r_zq_pend <= 1'b1;
        else if (w_zq_done)            r_zq_pend <= 1'b0;
      end
      r_zq_req <= (r_state == S_READY) && (w_next == S_ZQ_WAIT);
    end
  end

  assign app_if.app_zq_req = r_zq_req;
`else
  logic w_unused_zq;
  assign w_unused_zq       = i_sw_zq_req ^ app_if.app_zq_ack ^ (ZQI_CYCLES > 0);
  assign app_if.app_zq_req = 1'b0;
`endif

  assign app_if.app_ref_req = r_ref_req;
  assign app_if.app_sr_req  = r_sr_req;
  assign o_sr_active        = r_sr_active;
  assign o_ref_pending      = r_pend;
  assign o_err              = r_err;
  assign o_busy             = (r_state != S_IDLE) && (r_state != S_READY);

endmodule
